// File: rtl/sram_pkg.sv
// Shared constants for the word-addressed SRAM behind the I2C slave bridge.
// Enables are active low; ASSERTED_N / DEASSERTED_N name the two levels.
package sram_pkg;

    localparam int SRAM_ADDR_WIDTH = 8;
    localparam int SRAM_DATA_WIDTH = 16;
    localparam int SRAM_DEPTH      = 2 ** SRAM_ADDR_WIDTH;

    localparam logic ASSERTED_N   = 1'b0;
    localparam logic DEASSERTED_N = 1'b1;

endpackage

// File: rtl/sram_array.sv
// Storage array with reset initialisation and a registered read port (SRAM_INIT_PATTERN_EN selects init).
// Latency: write lands on the capturing edge; rdata valid one edge after re.
// Backpressure: none, accepts one access per cycle.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // One register per word so each can carry its own reset value.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
`ifdef SRAM_INIT_PATTERN_EN
        localparam logic [ADDR_WIDTH-1:0]              WORD_ADDR = ADDR_WIDTH'(g);
        localparam logic [DATA_WIDTH+2*ADDR_WIDTH-1:0] WORD_EXT  =
            (DATA_WIDTH+2*ADDR_WIDTH)'({WORD_ADDR, ~WORD_ADDR});
        localparam logic [DATA_WIDTH-1:0]              WORD_INIT = WORD_EXT[DATA_WIDTH-1:0];
`else
        localparam logic [DATA_WIDTH-1:0]              WORD_INIT = '0;
`endif
        logic [DATA_WIDTH-1:0] word_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                word_q <= WORD_INIT;
            end else if (we && (addr == ADDR_WIDTH'(g))) begin
                word_q <= wdata;
            end
        end

        assign mem[g] = word_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_256x16.sv
// Single-port 256x16 SRAM with bidirectional bus and active-low enables (SRAM_INIT_PATTERN_EN: pattern init).
// Latency: write in array after the capturing edge; read data on the bus one edge after the read.
// Backpressure: none; bus drive/release is combinational from the control pins.
module sram_256x16
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  chip_enable,
    input  logic                  write_enable,
    input  logic                  output_enable
);

    logic                  we;
    logic                  re;
    logic                  drive;
    logic [DATA_WIDTH-1:0] rdata;

    assign we = (chip_enable == ASSERTED_N) && (write_enable == ASSERTED_N);
    assign re = (chip_enable == ASSERTED_N) && (write_enable == DEASSERTED_N);

    // Reset gates the driver so the bus is released the instant reset rises.
    assign drive = re && (output_enable == ASSERTED_N) && !reset;

    assign data = drive ? rdata : {DATA_WIDTH{1'bz}};

    sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .re    (re),
        .addr  (address),
        .wdata (data),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_sram_256x16.sv
// Bench for sram_256x16: directed scenarios plus random accesses against an array model.
// An undriven bus floats high through tri1, so high-Z reads as 16'hFFFF.
module tb_sram_256x16;

    localparam logic [15:0] HIZ = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  address;
    logic        ce;
    logic        we_n;
    logic        oe;
    logic [15:0] tb_dat;
    logic        tb_drv;
    tri1  [15:0] data;

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_rd;

    assign data = tb_drv ? tb_dat : 16'hzzzz;

    always #5 clk = ~clk;

    sram_256x16 dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .data          (data),
        .chip_enable   (ce),
        .write_enable  (we_n),
        .output_enable (oe)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) begin
`ifdef SRAM_INIT_PATTERN_EN
            ref_mem[i] = {8'(i), ~8'(i)};
`else
            ref_mem[i] = 16'h0000;
`endif
        end
        ref_rd = 16'h0000;
    endtask

    // One bus cycle: controls set at negedge, model updated at the edge, bus checked just after.
    task automatic op(input string tag, input logic c, input logic w, input logic o,
                      input logic [7:0] a, input logic [15:0] d);
        logic [15:0] exp;
        @(negedge clk);
        ce      = c;
        we_n    = w;
        oe      = o;
        address = a;
        tb_dat  = d;
        tb_drv  = !c && !w;
        @(posedge clk);
        if (!c && !w)
            ref_mem[a] = d;
        else if (!c)
            ref_rd = ref_mem[a];
        #1;
        if (!c && !w)
            exp = d;
        else if (!c && !o)
            exp = ref_rd;
        else
            exp = HIZ;
        check(tag, data, exp);
    endtask

    // Caller leaves the RAM driving a read; a write attempted under reset must not land.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_hiz", data, HIZ);
        ce      = 1'b0;
        we_n    = 1'b0;
        oe      = 1'b0;
        address = 8'h10;
        tb_dat  = 16'hBEEF;
        tb_drv  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tb_drv = 1'b0;
        we_n   = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_rdata", data, 16'h0000);
        ce = 1'b1;
    endtask

    initial begin
        ce      = 1'b1;
        we_n    = 1'b1;
        oe      = 1'b1;
        address = 8'h00;
        tb_dat  = 16'h0000;
        tb_drv  = 1'b0;
        model_reset();
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        op("rst_rd00", 1'b0, 1'b1, 1'b0, 8'h00, 16'h0);
`ifdef SRAM_INIT_PATTERN_EN
        check("pat00", data, 16'h00FF);
`else
        check("zero00", data, 16'h0000);
`endif
        op("rst_rdff", 1'b0, 1'b1, 1'b0, 8'hFF, 16'h0);
`ifdef SRAM_INIT_PATTERN_EN
        check("patff", data, 16'hFF00);
        op("rd3c", 1'b0, 1'b1, 1'b0, 8'h3C, 16'h0);
        check("pat3c", data, 16'h3CC3);
`else
        check("zeroff", data, 16'h0000);
`endif

        op("wr10", 1'b0, 1'b0, 1'b1, 8'h10, 16'hA55A);
        op("rd10", 1'b0, 1'b1, 1'b0, 8'h10, 16'h0);
        check("a55a", data, 16'hA55A);
        @(negedge clk);
        address = 8'h77;
        #1;
        check("addr_hold", data, 16'hA55A);

        op("wr30_oe0", 1'b0, 1'b0, 1'b0, 8'h30, 16'h1234);
        op("rd30", 1'b0, 1'b1, 1'b0, 8'h30, 16'h0);
        check("own1234", data, 16'h1234);
        op("idle_hiz", 1'b1, 1'b1, 1'b0, 8'h30, 16'h0);
        op("rd_oe1_hiz", 1'b0, 1'b1, 1'b1, 8'h30, 16'h0);

        op("wr20", 1'b0, 1'b0, 1'b1, 8'h20, 16'h0001);
        op("wr21", 1'b0, 1'b0, 1'b1, 8'h21, 16'h0002);
        op("rd20", 1'b0, 1'b1, 1'b0, 8'h20, 16'h0);
        check("b2b0", data, 16'h0001);
        op("rd21", 1'b0, 1'b1, 1'b0, 8'h21, 16'h0);
        check("b2b1", data, 16'h0002);

        op("rd10_pre", 1'b0, 1'b1, 1'b0, 8'h10, 16'h0);
        do_reset();
        op("rd10_post", 1'b0, 1'b1, 1'b0, 8'h10, 16'h0);
`ifdef SRAM_INIT_PATTERN_EN
        check("post10", data, 16'h10EF);
`else
        check("post10", data, 16'h0000);
`endif

        for (int n = 0; n < 400; n++) begin
            logic        c;
            logic        w;
            logic        o;
            logic [7:0]  a;
            logic [15:0] d;
            c = ($urandom_range(0, 3) == 0);
            w = 1'($urandom_range(0, 1));
            o = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                             : 8'h40 + 8'($urandom_range(0, 7));
            d = 16'($urandom);
            op("rand", c, w, o, a, d);
            if (n == 200) begin
                op("rand_rd", 1'b0, 1'b1, 1'b0, 8'h41, 16'h0);
                do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_256x16.md
# sram_256x16

Single-port, word-addressed synchronous static RAM, 256 × 16 bits by default, with a bidirectional data bus and active-low chip, write and output enables. It is the storage behind the I2C SRAM slave bridge. The bridge drives the address and control lines, drives the bus during writes, and samples the bus during reads.

## Interface
- ADDR_WIDTH, default 8: address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, default 16: word width.
- clk  in  1  single clock; all storage updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  word address.
- data  inout  DATA_WIDTH  bidirectional data bus; high-Z whenever the RAM is not driving it.
- chip_enable  in  1  active low; 1 = RAM idle.
- write_enable  in  1  active low; 0 = write, 1 = read.
- output_enable  in  1  active low; 0 = RAM may drive data.

## Operation
- Storage: array mem[0..DEPTH-1] of DATA_WIDTH bits, plus a read register rdata.
- Write cycle (chip_enable=0, write_enable=0), on posedge clk: mem[address] <= data.
  - output_enable is ignored during a write.
  - The RAM never drives the bus during a write.
- Read cycle (chip_enable=0, write_enable=1), on posedge clk: rdata <= mem[address].
- Bus drive: data = rdata when chip_enable=0, write_enable=1, output_enable=0 and reset=0. Otherwise data is high-Z.
- Idle (chip_enable=1): no update to mem or rdata; bus is high-Z.
- Address is always in range; no wrap logic is needed.
- X or Z on the bus during a write is stored as-is. The bridge guarantees bus ownership.
- Reset:
  - Asserting reset asynchronously clears rdata to 0 and releases the bus.
  - The memory is initialised per Configuration; the initialisation is applied while reset is high.
  - Writes are blocked while reset is high.
  - Deasserting reset mid-transaction resumes normal decode on the next posedge.

## Timing
- Write latency: data is in the array after the capturing edge. A read of the same address issued in the next cycle returns the new value.
- Read latency: 1 cycle. The address is presented before edge N; the value appears on the bus after edge N, once output_enable=0.
- Bus enable/disable is combinational from the control inputs. Turnaround to high-Z happens in the same cycle output_enable or write_enable changes.
- Reads and writes cannot occur in the same cycle: write_enable selects exactly one.
- Changing the address without a clock edge does not change the driven data; the bus holds the last rdata.

## Configuration
- SRAM_INIT_PATTERN_EN:
  - Defined: reset loads mem[a] = {a, ~a}, zero-extended or truncated to DATA_WIDTH (for 8/16 this is upper byte = a, lower byte = bitwise NOT of a).
  - Undefined: reset loads every word with 0.
  - rdata is cleared to 0 in both cases.

## Structure
- Package sram_pkg:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - DEPTH constant.
  - Active-low level constants ASSERTED_N=0 and DEASSERTED_N=1 for the three enables.
- One sub-module, sram_array:
  - Holds the storage array, reset initialisation and read register.
  - Interface: clk, reset, we, re, addr, wdata, rdata.
- The top level decodes the active-low controls into we/re and owns the tristate on data.

## Test plan
- Reset, pattern macro undefined: after reset, read address 0x00 and 0xFF with oe=0 → bus reads 0x0000 both times.
- Write 0xA55A to address 0x10, then read 0x10 → bus shows 0xA55A one cycle after the read edge.
- Bus ownership: with write_enable=0 and output_enable=0, the bench drives 0x1234 → no contention and the stored value is 0x1234. With chip_enable=1 and output_enable=0 → bus is high-Z.
- Back-to-back: write 0x0001 to address 0x20, then write 0x0002 to address 0x21, then read 0x20 and 0x21 → bus returns 0x0001 then 0x0002, each one cycle after its read edge.
- Pattern macro defined: after reset, read address 0x3C → 0x3CC3. Read address 0xFF → 0xFF00.
- Reset mid-read: assert reset while the RAM is driving 0xA55A → bus goes high-Z immediately. After release, a read of 0x10 returns the reset-initialised value (0x0000 without the macro).
